// File: rtl/mem_read_arbiter.sv
// Arbitrates the shared memory read port between instruction fetch (I) and data (D),
// tracking in-flight read owners in an in-order tag FIFO. Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_read_arbiter #(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_raddr,
  output logic [15:0] i_rdata,
  input  logic        i_flush,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_raddr,
  output logic [15:0] d_rdata,
  output logic        mem_re,
  output logic [15:0] mem_raddr,
  input  logic        mem_ready,
  input  logic [15:0] mem_addr_out,
  input  logic [15:0] mem_data_out,
  output logic        err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam logic [PTR_W:0]   MAX_CNT = (PTR_W+1)'(MAX_OUT);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W:0]     count_r;
  logic [MAX_OUT-1:0] owner_r;
  logic [MAX_OUT-1:0] kill_r;
  logic [MAX_OUT-1:0] owner_nxt_s;
  logic [MAX_OUT-1:0] kill_nxt_s;
  logic               can_issue_s;
  logic               push_s;
  logic               pop_s;
  logic               head_owner_s;
  logic               head_kill_s;
  logic               resp_ok_s;
  logic               i_gnt_s;
  logic               d_gnt_s;
  logic               err_r;
  logic               i_rvalid_r;
  logic               d_rvalid_r;
  logic [15:0]        i_raddr_r;
  logic [15:0]        i_rdata_r;
  logic [15:0]        d_raddr_r;
  logic [15:0]        d_rdata_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_winner_r;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_r;
  logic          force_i_s;
`endif

  // FIFO occupancy and head decode; a pop frees a slot for this cycle's grant
  always_comb begin
    can_issue_s  = (count_r < MAX_CNT) || mem_ready;
    pop_s        = mem_ready && (count_r != '0);
    head_owner_s = owner_r[rd_ptr_r];
    head_kill_s  = kill_r[rd_ptr_r] | (i_flush & ~head_owner_s);
    resp_ok_s    = pop_s & ~head_kill_s;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin grant: on contention the requester that did not win last is served
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!reset && can_issue_s) begin
      if (i_req && !i_flush && d_req) begin
        if (last_winner_r) begin
          i_gnt_s = 1'b1;
        end else begin
          d_gnt_s = 1'b1;
        end
      end else if (i_req && !i_flush) begin
        i_gnt_s = 1'b1;
      end else if (d_req) begin
        d_gnt_s = 1'b1;
      end else begin
        i_gnt_s = 1'b0;
      end
    end else begin
      d_gnt_s = 1'b0;
    end
  end
`else
  // Fixed D priority with a starvation escape for I
  always_comb begin
    i_gnt_s   = 1'b0;
    d_gnt_s   = 1'b0;
    force_i_s = (starve_r == STARVE_MAX);
    if (!reset && can_issue_s) begin
      d_gnt_s = d_req & ~force_i_s;
      i_gnt_s = i_req & ~i_flush & (~d_req | force_i_s);
    end else begin
      d_gnt_s = 1'b0;
    end
  end
`endif

  assign push_s    = i_gnt_s | d_gnt_s;
  assign i_gnt     = i_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign mem_re    = push_s;
  assign mem_raddr = d_gnt_s ? d_addr : i_addr;

  // Next tag contents: flush kills every I entry, then the new grant is written
  always_comb begin
    owner_nxt_s = owner_r;
    kill_nxt_s  = kill_r;
    if (i_flush) begin
      kill_nxt_s = kill_r | ~owner_r;
    end else begin
      kill_nxt_s = kill_r;
    end
    if (push_s) begin
      owner_nxt_s[wr_ptr_r] = d_gnt_s;
      kill_nxt_s[wr_ptr_r]  = 1'b0;
    end else begin
      owner_nxt_s = owner_r;
    end
  end

  // Tag FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      owner_r  <= '0;
      kill_r   <= '0;
    end else begin
      owner_r <= owner_nxt_s;
      kill_r  <= kill_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else        rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Response routing one cycle after mem_ready; data holds between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      i_raddr_r  <= 16'h0000;
      i_rdata_r  <= 16'h0000;
      d_raddr_r  <= 16'h0000;
      d_rdata_r  <= 16'h0000;
      err_r      <= 1'b0;
    end else begin
      i_rvalid_r <= resp_ok_s & ~head_owner_s;
      d_rvalid_r <= resp_ok_s & head_owner_s;
      if (resp_ok_s && !head_owner_s) begin
        i_raddr_r <= mem_addr_out;
        i_rdata_r <= mem_data_out;
      end else begin
        i_raddr_r <= i_raddr_r;
        i_rdata_r <= i_rdata_r;
      end
      if (resp_ok_s && head_owner_s) begin
        d_raddr_r <= mem_addr_out;
        d_rdata_r <= mem_data_out;
      end else begin
        d_raddr_r <= d_raddr_r;
        d_rdata_r <= d_rdata_r;
      end
      err_r <= err_r | (mem_ready && (count_r == '0));
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember the most recent winner (reset favours I by recording D)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_r <= 1'b1;
    end else if (d_gnt_s) begin
      last_winner_r <= 1'b1;
    end else if (i_gnt_s) begin
      last_winner_r <= 1'b0;
    end else begin
      last_winner_r <= last_winner_r;
    end
  end
`else
  // Count consecutive denied I cycles; a flush cycle neither counts nor clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_r <= '0;
    end else if (i_gnt_s || !i_req) begin
      starve_r <= '0;
    end else if (!i_flush && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end
`endif

  assign i_rvalid = i_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign i_raddr  = i_raddr_r;
  assign i_rdata  = i_rdata_r;
  assign d_raddr  = d_raddr_r;
  assign d_rdata  = d_rdata_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter (MAX_OUT=4, STARVE_LIMIT=3).
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, d_req, mem_ready;
  logic [15:0] i_addr, d_addr, mem_addr_out, mem_data_out;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_re, err;
  logic [15:0] i_raddr, i_rdata, d_raddr, d_rdata, mem_raddr;

  int err_cnt = 0;
  int chk_cnt = 0;

  mem_read_arbiter #(.MAX_OUT(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_raddr(i_raddr), .i_rdata(i_rdata), .i_flush(i_flush),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_raddr(d_raddr), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [15:0] a, input logic [15:0] d);
    mem_ready    = 1'b1;
    mem_addr_out = a;
    mem_data_out = d;
  endtask

  initial begin
    logic [3:0] own_v;
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_flush = 1'b0; mem_ready = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; mem_addr_out = 16'h0000; mem_data_out = 16'h0000;
    #12;
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_mem_re", {31'd0, mem_re}, 32'd0);
    check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b0;
    step();

    // single fetch read, response one cycle after grant
    i_req = 1'b1; i_addr = 16'h0010;
    #1;
    check("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("t1_raddr", {16'd0, mem_raddr}, 32'h0010);
    step();
    i_req = 1'b0;
    resp(16'h0010, 16'hABCD);
    check("t1_rv_early", {31'd0, i_rvalid}, 32'd0);
    step();
    mem_ready = 1'b0;
    check("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("t1_i_raddr", {16'd0, i_raddr}, 32'h0010);
    check("t1_i_rdata", {16'd0, i_rdata}, 32'hABCD);
    check("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    step();
    check("t1_pulse", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("t1_hold", {16'd0, i_rdata}, 32'hABCD);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // round robin: both requesting, 1-cycle memory -> I,D,I,D
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) resp(16'h0A00, 16'h0000);
      #1;
      check("rr_i_gnt", {31'd0, i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_d_gnt", {31'd0, d_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    mem_ready = 1'b0;
    step();
`else
    // starvation escape with memory stalled
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t2_d_win", {30'd0, i_gnt, d_gnt}, 32'd1);
      check("t2_d_addr", {16'd0, mem_raddr}, 32'h0200);
      step();
    end
    #1;
    check("t2_i_forced", {30'd0, i_gnt, d_gnt}, 32'd2);
    check("t2_i_addr", {16'd0, mem_raddr}, 32'h0100);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t2_full", {31'd0, mem_re}, 32'd0);
      step();
    end
    resp(16'h0200, 16'h1111);
    #1;
    check("t2_regrant", {30'd0, i_gnt, d_gnt}, 32'd1);
    step();
    i_req = 1'b0; d_req = 1'b0;
    check("t2_d_rv0", {30'd0, i_rvalid, d_rvalid}, 32'd1);
    check("t2_d_rd0", {16'd0, d_rdata}, 32'h1111);
    own_v = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      resp(16'h0A00 + 16'(k), 16'h2000 + 16'(k));
      step();
      check("t2_drain_rv", {30'd0, i_rvalid, d_rvalid}, own_v[k] ? 32'd1 : 32'd2);
      check("t2_drain_data", {16'd0, own_v[k] ? d_rdata : i_rdata}, 32'h2000 + k);
    end
    mem_ready = 1'b0;
    step();
`endif

    // flush kills two in-flight I reads, D survives
    i_req = 1'b1; d_req = 1'b0; i_addr = 16'h0300;
    #1;
    check("t3_i_gnt", {31'd0, i_gnt}, 32'd1);
    step();
    i_req = 1'b0; d_req = 1'b1; d_addr = 16'h0400;
    step();
    i_req = 1'b1; d_req = 1'b0; i_addr = 16'h0302;
    step();
    i_flush = 1'b1;
    #1;
    check("t3_flush_gnt", {31'd0, i_gnt}, 32'd0);
    check("t3_flush_re", {31'd0, mem_re}, 32'd0);
    step();
    i_flush = 1'b0; i_req = 1'b0;
    own_v = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      resp(16'h0B00 + 16'(k), 16'h3000 + 16'(k));
      step();
      check("t3_rv", {30'd0, i_rvalid, d_rvalid}, own_v[k] ? 32'd1 : 32'd0);
    end
    mem_ready = 1'b0;
    check("t3_d_data", {16'd0, d_rdata}, 32'h3001);
    step();

    // flush in the same cycle the I head returns; D granted during flush
    i_req = 1'b1; i_addr = 16'h0500;
    step();
    i_flush = 1'b1; d_req = 1'b1; d_addr = 16'h0600;
    resp(16'h0500, 16'h5555);
    #1;
    check("t4_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("t4_raddr", {16'd0, mem_raddr}, 32'h0600);
    step();
    i_flush = 1'b0; i_req = 1'b0; d_req = 1'b0;
    check("t4_no_irv", {31'd0, i_rvalid}, 32'd0);
    resp(16'h0600, 16'h6666);
    step();
    mem_ready = 1'b0;
    check("t4_d_rv", {31'd0, d_rvalid}, 32'd1);
    check("t4_d_data", {16'd0, d_rdata}, 32'h6666);
    step();

    // response with empty FIFO, then asynchronous reset
    resp(16'h0700, 16'h7777);
    step();
    mem_ready = 1'b0;
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_no_rv", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    step();
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    i_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_err", {31'd0, err}, 32'd0);
    check("t5_rst_data", {d_raddr, d_rdata}, 32'd0);
    check("t5_rst_re", {31'd0, mem_re}, 32'd0);
    step();
    reset = 1'b0; i_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single memory read port between the instruction-fetch requester (I) and the load/data requester (D).
- Each cycle it arbitrates requests, drives mem_re/mem_raddr, and records the owner of each in-flight read in an in-order tag FIFO.
- Routes each mem_ready response back to its owner one cycle later.
- Supports a fetch flush that kills in-flight instruction reads after a taken branch.

Parameters:
- MAX_OUT, 4, maximum in-flight reads (tag FIFO depth, power of 2, >=2)
- STARVE_LIMIT, 3, consecutive denied I-request cycles before I is forced to win

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch requests a read this cycle
- i_addr  in  16  fetch read address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  instruction response valid (registered)
- i_raddr  out  16  address of instruction response
- i_rdata  out  16  instruction word
- i_flush  in  1  branch taken: discard all in-flight fetch reads
- d_req  in  1  data requester requests a read
- d_addr  in  16  data read address
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (registered)
- d_raddr  out  16  address of data response
- d_rdata  out  16  data word
- mem_re  out  1  read enable to memory
- mem_raddr  out  16  read address to memory
- mem_ready  in  1  memory returns one response (in request order)
- mem_addr_out  in  16  address of returned response
- mem_data_out  in  16  returned data
- err  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous: tag FIFO empty (count=0, rd/wr pointers 0), starve counter 0, err=0, i_rvalid=d_rvalid=0, i_/d_raddr and rdata=0. While reset is high, i_gnt=d_gnt=mem_re=0.
- Tag entry holds {owner, kill}; owner 0=I, 1=D.
- can_issue = (count < MAX_OUT) || mem_ready. A pop frees a slot in the same cycle.
- Arbitration, combinational:
  - d_gnt = can_issue & d_req & !force_i.
  - i_gnt = can_issue & i_req & !i_flush & (!d_req | force_i).
  - force_i = (starve == STARVE_LIMIT).
  - At most one grant per cycle.
- mem_re = i_gnt | d_gnt. mem_raddr = d_gnt ? d_addr : i_addr. mem_raddr = i_addr when idle.
- On grant: push {owner, kill=0}.
- starve counter:
  - increments, saturating at STARVE_LIMIT, when i_req & !i_gnt & !i_flush;
  - clears on i_gnt or !i_req.
- On mem_ready:
  - pop head;
  - next cycle assert the owner's rvalid with raddr=mem_addr_out and rdata=mem_data_out, unless the kill bit is set (then no rvalid).
  - Latency: mem_ready cycle N -> rvalid cycle N+1.
  - rvalid is a single-cycle pulse; rdata/raddr hold their last value otherwise.
- Simultaneous push and pop: count unchanged, both pointers advance.
- i_flush:
  - sets kill on every FIFO entry with owner I, including the head popped in the same cycle, whose response is then suppressed;
  - D entries unaffected;
  - i_gnt forced 0 in the flush cycle; D may still be granted.
- mem_ready with count==0: sets err=1 (sticky until reset); no rvalid, FIFO unchanged.
- Pointer wrap: modulo MAX_OUT; count is log2(MAX_OUT)+1 bits.
- Reset mid-operation: all in-flight tags dropped; responses arriving after reset deassertion with count==0 set err.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - fixed D priority and the starve counter are replaced by a 1-bit last_winner register (reset = D);
  - on simultaneous i_req & d_req (no flush), the requester that did not win last is granted;
  - last_winner updates on every grant.
- Not defined: fixed D priority with the STARVE_LIMIT escape, as above.

Test Plan:
- i_req=1, i_addr=0x0010, d_req=0, memory returns mem_ready 1 cycle later with data 0xABCD -> i_gnt=1 and mem_raddr=0x0010 in cycle 0; i_rvalid=1, i_raddr=0x0010, i_rdata=0xABCD in cycle 2; d_rvalid never asserts.
- i_req and d_req held high, memory stalled (mem_ready=0), MAX_OUT=4 -> D granted 3 cycles, I granted on the 4th (starve escape); gnts then 0 while count=4; the first mem_ready cycle grants again.
- Two I reads and one D read in flight, i_flush pulsed, three mem_ready responses -> only d_rvalid pulses; both I responses suppressed; count returns to 0.
- i_flush in the same cycle as mem_ready for an I head entry -> no i_rvalid next cycle; i_gnt=0 in that cycle even with i_req=1.
- mem_ready=1 with empty FIFO after reset -> err=1 and stays 1; reset pulse -> err=0, all outputs at reset values immediately (asynchronous).
- MEM_ARB_ROUND_ROBIN_EN, both requesting continuously with a 1-cycle memory -> grants alternate I,D,I,D starting with I.
